// File: rtl/game_pkg.sv
// Shared types and defaults for the game sequencer and its timing helpers.
package game_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_WAIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ATTACK = 3'd3,
    S_MOVE   = 3'd4,
    S_DRAW   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int unsigned FRAME_DIV_DEFAULT = 833333;
  localparam int unsigned TIMEOUT_DEFAULT   = 1048576;
  localparam int unsigned CNT_W_DEFAULT     = 20;

endpackage

// File: rtl/game_control_frame_ticker.sv
// Free-running divider: counts 0..DIV-1 and flags the last count as a one-cycle tick.
module frame_ticker
  import game_pkg::*;
#(
  parameter int unsigned DIV   = FRAME_DIV_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_control.sv
// Game sequencer: one command at a time, frame-paced key sampling, watchdog and overrun status.
module game_control
  import game_pkg::*;
#(
  parameter int unsigned FRAME_DIV = FRAME_DIV_DEFAULT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_attack,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       init_done,
  input  logic       idle_done,
  input  logic       attack_done,
  input  logic       move_done,
  input  logic       draw_done,
  output logic       init,
  output logic       idle,
  output logic       attack,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       draw,
  output logic [2:0] state_dbg,
  output logic       frame_overrun,
  output logic       wdg_error
);

  localparam logic [CNT_W-1:0] WDG_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  dir_e             move_dir_q, move_dir_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             wdg_err_q, wdg_err_d;
  logic [CNT_W-1:0] wdg_cnt_q, wdg_cnt_d;
  logic             tick;
  logic             decide;
  logic             done_match;
  logic             timeout;

  frame_ticker #(
    .DIV   (FRAME_DIV),
    .CNT_W (CNT_W)
  ) u_frame_ticker (
    .clock  (clock),
    .reset  (reset),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    move_dir_d = move_dir_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    wdg_err_d  = wdg_err_q;
    decide     = 1'b0;
    done_match = 1'b0;

    case (state_q)
      S_INIT: begin
        done_match = init_done;
        if (init_done) state_d = S_DRAW;
      end
      S_WAIT: begin
        if (pending_q || tick) begin
          decide = 1'b1;
          if (key_attack) begin
            state_d = S_ATTACK;
          end else if (key_up) begin
            state_d    = S_MOVE;
            move_dir_d = DIR_UP;
          end else if (key_down) begin
            state_d    = S_MOVE;
            move_dir_d = DIR_DOWN;
          end else if (key_left) begin
            state_d    = S_MOVE;
            move_dir_d = DIR_LEFT;
          end else if (key_right) begin
            state_d    = S_MOVE;
            move_dir_d = DIR_RIGHT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        done_match = idle_done;
        if (idle_done) state_d = S_DRAW;
      end
      S_ATTACK: begin
        done_match = attack_done;
        if (attack_done) state_d = S_DRAW;
      end
      S_MOVE: begin
        done_match = move_done;
        if (move_done) state_d = S_DRAW;
      end
      S_DRAW: begin
        done_match = draw_done;
        if (draw_done) state_d = S_WAIT;
      end
      default: state_d = S_INIT;
    endcase

    // A done arriving on the timeout cycle still completes the command.
    timeout = (state_q != S_WAIT) && (wdg_cnt_q == WDG_LAST) && !done_match;
    if (timeout) begin
      state_d   = S_INIT;
      wdg_err_d = 1'b1;
    end

    if (timeout) begin
      pending_d = 1'b0;
    end else if (decide) begin
      pending_d = pending_q & tick;
    end else if (tick) begin
      if (pending_q) overrun_d = 1'b1;
      pending_d = 1'b1;
    end

    if (timeout || (state_d != state_q) || (state_q == S_WAIT)) wdg_cnt_d = '0;
    else                                                        wdg_cnt_d = wdg_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_INIT;
      move_dir_q <= DIR_UP;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      wdg_err_q  <= 1'b0;
      wdg_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      move_dir_q <= move_dir_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      wdg_err_q  <= wdg_err_d;
      wdg_cnt_q  <= wdg_cnt_d;
    end
  end

  always_comb begin
    init   = 1'b0;
    idle   = 1'b0;
    attack = 1'b0;
    up     = 1'b0;
    down   = 1'b0;
    left   = 1'b0;
    right  = 1'b0;
    draw   = 1'b0;
    case (state_q)
      S_INIT:   init   = 1'b1;
      S_IDLE:   idle   = 1'b1;
      S_ATTACK: attack = 1'b1;
      S_DRAW:   draw   = 1'b1;
      S_MOVE: begin
        case (move_dir_q)
          DIR_UP:    up    = 1'b1;
          DIR_DOWN:  down  = 1'b1;
          DIR_LEFT:  left  = 1'b1;
          DIR_RIGHT: right = 1'b1;
          default:   up    = 1'b0;
        endcase
      end
      default: init = 1'b0;
    endcase
  end

  assign state_dbg     = state_q;
  assign frame_overrun = overrun_q;
  assign wdg_error     = wdg_err_q;

endmodule

// File: tb/tb_game_control.sv
// Scoreboard bench: stimulus queues expected output changes, a negedge monitor compares each change.
module tb_game_control;

  localparam logic [2:0] ST_INIT = 3'd0, ST_WAIT = 3'd1, ST_IDLE = 3'd2,
                         ST_ATK  = 3'd3, ST_MOVE = 3'd4, ST_DRAW = 3'd5;
  // Command vector order: init idle attack up down left right draw
  localparam logic [7:0] C_NONE = 8'h00, C_INIT = 8'h80, C_IDLE = 8'h40, C_ATK = 8'h20,
                         C_UP = 8'h10, C_DOWN = 8'h08, C_LEFT = 8'h04, C_DRAW = 8'h01;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [7:0] cmd;
    logic       ovr;
    logic       wdg;
    int         dwell;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_attack = 1'b0, key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [4:0] done_v = '0;
  logic       init, idle, attack, up, down, left, right, draw;
  logic [2:0] state_dbg;
  logic       frame_overrun, wdg_error;
  logic [7:0] cmd_v;

  ev_t        exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_chg = 0;
  logic       mon_on = 1'b0;
  logic       mon_init = 1'b0;
  logic [12:0] prev_snap;

  always #5 clock = ~clock;

  game_control #(
    .FRAME_DIV (16),
    .TIMEOUT   (64),
    .CNT_W     (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .key_attack    (key_attack),
    .key_up        (key_up),
    .key_down      (key_down),
    .key_left      (key_left),
    .key_right     (key_right),
    .init_done     (done_v[0]),
    .idle_done     (done_v[1]),
    .attack_done   (done_v[2]),
    .move_done     (done_v[3]),
    .draw_done     (done_v[4]),
    .init          (init),
    .idle          (idle),
    .attack        (attack),
    .up            (up),
    .down          (down),
    .left          (left),
    .right         (right),
    .draw          (draw),
    .state_dbg     (state_dbg),
    .frame_overrun (frame_overrun),
    .wdg_error     (wdg_error)
  );

  assign cmd_v = {init, idle, attack, up, down, left, right, draw};

  always @(negedge clock) begin
    logic [12:0] snap;
    ev_t         e;
    cyc++;
    snap = {state_dbg, cmd_v, frame_overrun, wdg_error};
    if (mon_on) begin
      if (!mon_init) begin
        n_chk++;
        if (snap !== {ST_INIT, C_INIT, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL reset_state got %h want %h", snap, {ST_INIT, C_INIT, 1'b0, 1'b0});
        end
        prev_snap = snap;
        last_chg  = cyc;
        mon_init  = 1'b1;
      end else if (snap !== prev_snap) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change got %h (prev %h) want no change", snap, prev_snap);
        end else begin
          e = exp_q.pop_front();
          if (snap !== {e.st, e.cmd, e.ovr, e.wdg}) begin
            n_fail++;
            $display("FAIL %s outputs got st=%0d cmd=%h ovr=%b wdg=%b want st=%0d cmd=%h ovr=%b wdg=%b",
                     e.name, state_dbg, cmd_v, frame_overrun, wdg_error, e.st, e.cmd, e.ovr, e.wdg);
          end
          n_chk++;
          if (cyc - last_chg != e.dwell) begin
            n_fail++;
            $display("FAIL %s dwell got %0d want %0d", e.name, cyc - last_chg, e.dwell);
          end
        end
        prev_snap = snap;
        last_chg  = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse(input int idx);
    done_v[idx] = 1'b1;
    step(1);
    done_v[idx] = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state_dbg !== s && n < budget) begin
      step(1);
      n++;
    end
    n_chk++;
    if (state_dbg !== s) begin
      n_fail++;
      $display("FAIL wait_state got %0d want %0d within %0d cycles", state_dbg, s, budget);
    end
  endtask

  task automatic expect_ev(input string nm, input logic [2:0] st, input logic [7:0] cmd,
                           input logic ovr, input logic wdg, input int dw);
    ev_t e;
    e.name = nm; e.st = st; e.cmd = cmd; e.ovr = ovr; e.wdg = wdg; e.dwell = dw;
    exp_q.push_back(e);
  endtask

  initial begin
    // Cycle numbers below count from the first cycle after reset release;
    // frame ticks then fall on cycles 16, 32, 48, ...
    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_on = 1'b1;

    // init held 5 cycles, then draw, then wait
    expect_ev("init_to_draw", ST_DRAW, C_DRAW, 1'b0, 1'b0, 5);
    step(4);
    pulse(0);
    expect_ev("draw_to_wait", ST_WAIT, C_NONE, 1'b0, 1'b0, 2);
    step(1);
    pulse(4);

    // up beats right at the tick on cycle 16
    key_up = 1'b1; key_right = 1'b1;
    expect_ev("move_up", ST_MOVE, C_UP, 1'b0, 1'b0, 9);
    wait_state(ST_MOVE, 40);
    key_up = 1'b0; key_right = 1'b0;
    expect_ev("move_draw", ST_DRAW, C_DRAW, 1'b0, 1'b0, 3);
    step(2);
    pulse(3);
    expect_ev("move_wait", ST_WAIT, C_NONE, 1'b0, 1'b0, 1);
    pulse(4);

    // no keys at tick 32 -> idle; stray dones ignored
    pulse(4);
    expect_ev("idle", ST_IDLE, C_IDLE, 1'b0, 1'b0, 12);
    wait_state(ST_IDLE, 40);
    pulse(3);
    pulse(2);
    step(1);
    expect_ev("idle_draw", ST_DRAW, C_DRAW, 1'b0, 1'b0, 4);
    pulse(1);

    // attack beats left at tick 48; ticks 64 and 80 overrun
    key_attack = 1'b1; key_left = 1'b1;
    expect_ev("attack_wait", ST_WAIT, C_NONE, 1'b0, 1'b0, 1);
    expect_ev("attack", ST_ATK, C_ATK, 1'b0, 1'b0, 11);
    expect_ev("overrun", ST_ATK, C_ATK, 1'b1, 1'b0, 32);
    pulse(4);
    wait_state(ST_ATK, 40);
    key_attack = 1'b0; key_left = 1'b0;
    step(40);
    expect_ev("attack_draw", ST_DRAW, C_DRAW, 1'b1, 1'b0, 9);
    pulse(2);

    // pending tick decides immediately; move stalls into watchdog
    key_down = 1'b1;
    expect_ev("pend_wait", ST_WAIT, C_NONE, 1'b1, 1'b0, 2);
    expect_ev("move_down", ST_MOVE, C_DOWN, 1'b1, 1'b0, 1);
    expect_ev("watchdog", ST_INIT, C_INIT, 1'b1, 1'b1, 64);
    step(1);
    pulse(4);
    wait_state(ST_MOVE, 10);
    key_down = 1'b0;
    wait_state(ST_INIT, 100);
    expect_ev("wdg_init_draw", ST_DRAW, C_DRAW, 1'b1, 1'b1, 3);
    step(2);
    pulse(0);

    // reset during draw clears sticky flags and the pending tick
    expect_ev("reset_mid_draw", ST_INIT, C_INIT, 1'b0, 1'b0, 2);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_ev("rst_draw", ST_DRAW, C_DRAW, 1'b0, 1'b0, 2);
    step(1);
    pulse(0);
    expect_ev("rst_wait", ST_WAIT, C_NONE, 1'b0, 1'b0, 1);
    pulse(4);
    expect_ev("rst_idle", ST_IDLE, C_IDLE, 1'b0, 1'b0, 13);
    wait_state(ST_IDLE, 40);
    expect_ev("rst_idle_draw", ST_DRAW, C_DRAW, 1'b0, 1'b0, 1);
    pulse(1);
    expect_ev("rst_idle_wait", ST_WAIT, C_NONE, 1'b0, 1'b0, 1);
    pulse(4);

    // left beats right
    key_left = 1'b1; key_right = 1'b1;
    expect_ev("move_left", ST_MOVE, C_LEFT, 1'b0, 1'b0, 14);
    wait_state(ST_MOVE, 40);
    key_left = 1'b0; key_right = 1'b0;
    expect_ev("left_draw", ST_DRAW, C_DRAW, 1'b0, 1'b0, 1);
    pulse(3);
    expect_ev("left_wait", ST_WAIT, C_NONE, 1'b0, 1'b0, 1);
    pulse(4);
    step(5);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations got %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
